// File: rtl/aes_enc_if.sv
// Key/plaintext strobe and ciphertext/busy bundle for the aes_enc block encryptor.
interface aes_enc_if;
  logic         inKeyWr;
  logic [255:0] inKeyData;
  logic         inDataWr;
  logic [127:0] inDataData;
  logic [127:0] outData;
  logic         outBusy;

  modport master (
    output inKeyWr, inKeyData, inDataWr, inDataData,
    input  outData, outBusy
  );

  modport slave (
    input  inKeyWr, inKeyData, inDataWr, inDataData,
    output outData, outBusy
  );
endinterface

// File: rtl/aes_enc.sv
// Iterative AES-256 encryptor with on-the-fly key expansion, one round per clock.
// Define AES_ENC_UNROLL2_EN to compute two rounds per clock (7-cycle busy).
module aes_enc #(
  parameter int NR = 14
) (
  input  logic    inClk,
  input  logic    inRst,
  aes_enc_if.slave bus
);

`ifdef AES_ENC_UNROLL2_EN
  localparam logic [3:0] LAST_CNT = 4'(NR / 2);
`else
  localparam logic [3:0] LAST_CNT = 4'(NR);
`endif

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} fsm_e;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[11'd2047 - {x, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [2:0] idx);
    logic [7:0] r;
    case (idx)
      3'd1:    r = 8'h01;
      3'd2:    r = 8'h02;
      3'd3:    r = 8'h04;
      3'd4:    r = 8'h08;
      3'd5:    r = 8'h10;
      3'd6:    r = 8'h20;
      3'd7:    r = 8'h40;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // rk_{r+1} from (rk_{r-1}, rk_r); even indices use RotWord and Rcon.
  function automatic logic [127:0] next_rk(input logic [127:0] a, input logic [127:0] b,
                                           input logic even, input logic [7:0] rc);
    logic [31:0] t;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;
    if (even) begin
      t = sub_word({b[23:0], b[31:24]}) ^ {rc, 24'h000000};
    end else begin
      t = sub_word(b[31:0]);
    end
    w0 = a[127:96] ^ t;
    w1 = a[95:64] ^ w0;
    w2 = a[63:32] ^ w1;
    w3 = a[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [31:0]  col;
    logic [127:0] o;
    o = 128'h0;
    for (int i = 0; i < 16; i++) begin
      sb[i] = sbox(s[127-8*i -: 8]);
    end
    // Byte index is 4*column + row; row r rotates left by r columns.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4*c+r] = sb[4*((c+r)%4)+r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      col = {sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]};
      if (last) begin
        o[127-32*c -: 32] = col;
      end else begin
        o[127-32*c -: 32] = mix_col(col);
      end
    end
    return o ^ rk;
  endfunction

  fsm_e         fsm_q, fsm_d;
  logic [255:0] key_q, key_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] rka_q, rka_d;
  logic [127:0] rkb_q, rkb_d;
  logic [127:0] data_q, data_d;
  logic [3:0]   cnt_q, cnt_d;

  logic [255:0] key_sel_s;
  logic [127:0] rnd_blk_s;
  logic [127:0] rnd_rka_s;
  logic [127:0] rnd_rkb_s;

  // A key written together with the data is used directly for rk0/rk1.
  assign key_sel_s = bus.inKeyWr ? bus.inKeyData : key_q;

`ifdef AES_ENC_UNROLL2_EN
  logic [127:0] mid_rk_s;
  logic [127:0] mid_blk_s;

  // Rounds 2k-1 and 2k per clock; registers hold (rk_{2k-2}, rk_{2k-1}).
  always_comb begin
    mid_rk_s  = next_rk(rka_q, rkb_q, 1'b1, rcon(cnt_q[2:0]));
    mid_blk_s = enc_round(blk_q, rkb_q, 1'b0);
    rnd_blk_s = enc_round(mid_blk_s, mid_rk_s, cnt_q == LAST_CNT);
    rnd_rka_s = mid_rk_s;
    rnd_rkb_s = next_rk(rkb_q, mid_rk_s, 1'b0, 8'h00);
  end
`else
  logic [2:0] rcon_idx_s;

  // Round r = cnt_q uses rk_r while rk_{r+1} is expanded alongside.
  always_comb begin
    rcon_idx_s = 3'((cnt_q + 4'd1) >> 1);
    rnd_blk_s  = enc_round(blk_q, rkb_q, cnt_q == LAST_CNT);
    rnd_rka_s  = rkb_q;
    rnd_rkb_s  = next_rk(rka_q, rkb_q, cnt_q[0], rcon(rcon_idx_s));
  end
`endif

  // Next-state logic: start on idle data strobe, iterate, publish on the last round.
  always_comb begin
    fsm_d  = fsm_q;
    key_d  = key_q;
    blk_d  = blk_q;
    rka_d  = rka_q;
    rkb_d  = rkb_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    case (fsm_q)
      ST_IDLE: begin
        key_d = key_sel_s;
        if (bus.inDataWr) begin
          blk_d = bus.inDataData ^ key_sel_s[255:128];
          rka_d = key_sel_s[255:128];
          rkb_d = key_sel_s[127:0];
          cnt_d = 4'd1;
          fsm_d = ST_RUN;
        end else begin
          fsm_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        blk_d = rnd_blk_s;
        rka_d = rnd_rka_s;
        rkb_d = rnd_rkb_s;
        if (cnt_q == LAST_CNT) begin
          data_d = rnd_blk_s;
          cnt_d  = 4'd0;
          fsm_d  = ST_IDLE;
        end else begin
          cnt_d  = cnt_q + 4'd1;
          fsm_d  = ST_RUN;
        end
      end
      default: begin
        fsm_d = ST_IDLE;
        cnt_d = 4'd0;
      end
    endcase
  end

  // State registers with synchronous reset taking priority over strobes.
  always_ff @(posedge inClk) begin
    if (inRst) begin
      fsm_q  <= ST_IDLE;
      key_q  <= 256'h0;
      blk_q  <= 128'h0;
      rka_q  <= 128'h0;
      rkb_q  <= 128'h0;
      data_q <= 128'h0;
      cnt_q  <= 4'd0;
    end else begin
      fsm_q  <= fsm_d;
      key_q  <= key_d;
      blk_q  <= blk_d;
      rka_q  <= rka_d;
      rkb_q  <= rkb_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.outData = data_q;
  assign bus.outBusy = (fsm_q == ST_RUN);

endmodule

// File: tb/tb_aes_enc.sv
// Self-checking bench for aes_enc: FIPS/SP800 vectors, handshake corner cases and a
// chained random run compared against a byte-level AES-256 reference model.
module tb_aes_enc;

`ifdef AES_ENC_UNROLL2_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 14;
`endif

  localparam logic [255:0] K_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] P_C3  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] K_SP  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] P_SP  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C_SP  = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [7:0] m_sbox [256];

  aes_enc_if bus ();

  aes_enc dut (
    .inClk (clk),
    .inRst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {m_sbox[w[31:24]], m_sbox[w[23:16]], m_sbox[w[15:8]], m_sbox[w[7:0]]};
  endfunction

  // Textbook AES-256: full 60-word key expansion, then 14 rounds on a byte array.
  function automatic logic [127:0] ref_enc(input logic [255:0] key, input logic [127:0] pt);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
        rc  = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
    for (int r = 0; r <= 14; r++) begin
      if (r > 0) begin
        for (int i = 0; i < 16; i++) s[i] = m_sbox[s[i]];
        for (int c = 0; c < 4; c++)
          for (int row = 0; row < 4; row++) t[4*c+row] = s[4*((c+row)%4)+row];
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          if (r < 14) begin
            s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
          end else begin
            s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
          end
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Called away from the rising edge; strobes are held for exactly one edge.
  task automatic start(input logic [255:0] k, input logic kw, input logic [127:0] p, input logic dw);
    bus.inKeyData  = k;
    bus.inKeyWr    = kw;
    bus.inDataData = p;
    bus.inDataWr   = dw;
    @(posedge clk);
    #1;
    bus.inKeyWr  = 1'b0;
    bus.inDataWr = 1'b0;
  endtask

  // Counts busy cycles (bounded), checks outData is held, then checks the result.
  // Returns at the negedge of the first idle cycle.
  task automatic wait_done(input string tag, input logic [127:0] exp_ct,
                           input logic [127:0] held, input int pre);
    int n;
    n = pre;
    @(negedge clk);
    while (bus.outBusy === 1'b1 && n < 40) begin
      n++;
      chk({tag, "_hold"}, bus.outData, held);
      @(negedge clk);
    end
    chk({tag, "_lat"}, 128'(n), 128'(LAT));
    chk({tag, "_busy"}, 128'(bus.outBusy), 128'h0);
    chk({tag, "_ct"}, bus.outData, exp_ct);
  endtask

  initial begin
    logic [255:0] key;
    logic [255:0] nkey;
    logic [127:0] pt;
    logic [127:0] ct;
    logic [127:0] prev;
    logic [7:0]   inv;

    checks = 0;
    errors = 0;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      m_sbox[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

    rst            = 1'b1;
    bus.inKeyWr    = 1'b0;
    bus.inKeyData  = 256'h0;
    bus.inDataWr   = 1'b0;
    bus.inDataData = 128'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 128'(bus.outBusy), 128'h0);
    chk("rst_data", bus.outData, 128'h0);
    rst = 1'b0;

    // Known-answer vectors with key and data written together.
    start(K_C3, 1'b1, P_C3, 1'b1);
    wait_done("c3", C_C3, 128'h0, 0);
    start(K_SP, 1'b1, P_SP, 1'b1);
    wait_done("sp", C_SP, C_C3, 0);

    // Key-only write, then data-only write with junk on the key bus.
    start(K_C3, 1'b1, 128'(rand256()), 1'b0);
    @(negedge clk);
    chk("keyonly_busy", 128'(bus.outBusy), 128'h0);
    chk("keyonly_data", bus.outData, C_SP);
    repeat (3) @(negedge clk);
    start(rand256(), 1'b0, P_C3, 1'b1);
    wait_done("persist", C_C3, C_SP, 0);

    // Strobes while busy must be ignored.
    start(K_C3, 1'b1, P_C3, 1'b1);
    repeat (5) @(negedge clk);
    start(rand256(), 1'b1, P_SP, 1'b1);
    wait_done("busy_strobe", C_C3, C_C3, 5);
    start(rand256(), 1'b0, P_SP, 1'b1);
    wait_done("busy_keykept", ref_enc(K_C3, P_SP), C_C3, 0);

    // Reset in the middle of an encryption.
    start(K_SP, 1'b1, P_SP, 1'b1);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 128'(bus.outBusy), 128'h0);
    chk("midrst_data", bus.outData, 128'h0);
    start(K_SP, 1'b1, P_SP, 1'b1);
    wait_done("after_rst", C_SP, 128'h0, 0);

    // Chained blocks, each written in the first idle cycle.
    key  = rand256();
    pt   = 128'(rand256());
    prev = C_SP;
    for (int i = 0; i < 10; i++) begin
      ct = ref_enc(key, pt);
      start(key, 1'b1, pt, 1'b1);
      wait_done($sformatf("chain%0d", i), ct, prev, 0);
      nkey = {key[127:0], pt};
      key  = nkey;
      pt   = ct;
      prev = ct;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
